// File: rtl/regfile_pkg.sv
// Shared register-file types and default widths used by the file and its read-side masters.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks a register-file address window and streams addr/data beats for debug snapshot and context save.
// Latency: first beat valid 2 cycles after the accepted start, then one beat per cycle.
// Backpressure: one output register holds the beat steady while out_ready is low; reads pause.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int DATA = REGFILE_DATA_W,
    parameter int ADDR = REGFILE_ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [ADDR-1:0] base,
    input  logic [ADDR:0]   count,
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] raddr,
    input  logic [DATA-1:0] rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ADDR-1:0] out_addr,
    output logic [DATA-1:0] out_data,
    output logic            out_last
);

    localparam logic [ADDR:0]   DEPTH_CNT = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR:0]   REM_ONE   = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR-1:0] PTR_ONE   = {{(ADDR-1){1'b0}}, 1'b1};

    dump_state_t     state, state_nxt;
    logic [ADDR-1:0] ptr, ptr_nxt;
    logic [ADDR:0]   remaining, remaining_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            out_valid_nxt;
    logic            out_last_nxt;
    logic [ADDR-1:0] out_addr_nxt;
    logic [DATA-1:0] out_data_nxt;
    logic            load;

    // The read address comes straight from the pointer register, so rdata
    // always belongs to the address the beat will be tagged with.
    assign raddr = ptr;
    assign load  = !out_valid || out_ready;

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        out_addr_nxt  = out_addr;
        out_data_nxt  = out_data;

        if (abort && state != IDLE) begin
            state_nxt     = IDLE;
            busy_nxt      = 1'b0;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (count == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            ptr_nxt       = base;
                            remaining_nxt = (count > DEPTH_CNT) ? DEPTH_CNT : count;
                            busy_nxt      = 1'b1;
                            state_nxt     = RUN;
                        end
                    end
                end
                RUN: begin
                    if (load) begin
                        out_data_nxt  = rdata;
                        out_addr_nxt  = ptr;
                        out_last_nxt  = (remaining == REM_ONE);
                        out_valid_nxt = 1'b1;
                        ptr_nxt       = ptr + PTR_ONE;
                        remaining_nxt = remaining - REM_ONE;
                        if (remaining == REM_ONE) begin
                            state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        busy_nxt      = 1'b0;
                        done_nxt      = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            out_addr  <= out_addr_nxt;
            out_data  <= out_data_nxt;
        end
    end

endmodule
